// File: rtl/ahb_lite_bus_arbiter_if.sv
// ahb_lite_bus_arbiter_if: bus bundle between up to four AHB-Lite masters, the arbiter and the fabric
//   master modport: requesters/fabric side (drive requests, address/data buses, HREADY; see grant and muxed bus)
//   slave  modport: arbiter side (sees requests and buses; drives grant, muxed address/data, HMASTER, HMASTLOCK)
interface ahb_lite_bus_arbiter_if #(parameter int NM = 2);
    logic [NM-1:0]    M_HBUSREQ;
    logic [NM-1:0]    M_HLOCK;
    logic [NM*32-1:0] M_HADDR;
    logic [NM*2-1:0]  M_HTRANS;
    logic [NM-1:0]    M_HWRITE;
    logic [NM*3-1:0]  M_HSIZE;
    logic [NM*32-1:0] M_HWDATA;
    logic [NM-1:0]    M_HGRANT;
    logic             HREADY;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [31:0]      HWDATA;
    logic [1:0]       HMASTER;
    logic             HMASTLOCK;
    modport master (
        output M_HBUSREQ, M_HLOCK, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, HREADY,
        input  M_HGRANT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER, HMASTLOCK
    );
    modport slave (
        input  M_HBUSREQ, M_HLOCK, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, HREADY,
        output M_HGRANT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_lite_bus_arbiter.sv
// ahb_lite_bus_arbiter: round-robin AHB-Lite arbiter for up to four masters with park on master 0
//   HCLK    : system clock
//   HRESETn : asynchronous active-low reset
//   bus     : ahb_lite_bus_arbiter_if.slave (requests, locks, master buses in; grant, muxed
//             address/control, data-phase HWDATA, HMASTER, HMASTLOCK out; HREADY in)
//   Optional: define ARB_HOLD_LIMIT_EN to force re-arbitration after MAX_HOLD unlocked cycles.
module ahb_lite_bus_arbiter #(
    parameter int NM       = 2,
    parameter int MAX_HOLD = 16
) (
    input logic HCLK,
    input logic HRESETn,
    ahb_lite_bus_arbiter_if.slave bus
);
    localparam logic [2:0] NM_L = 3'(NM);
    logic [1:0]  g_q, g_d, a_q, d_q;
    logic        l_q;
    logic [1:0]  g_s, a_s, d_s;
    logic [3:0]  req, lock, wr;
    logic [31:0] addr_m [4];
    logic [31:0] wdata_m [4];
    logic [1:0]  trans_m [4];
    logic [2:0]  size_m [4];
    logic [1:0]  idx;
    logic        found, expired;
    // Out-of-range indices can only appear through corruption; fold them onto master 0.
    assign g_s = ({1'b0, g_q} < NM_L) ? g_q : 2'd0;
    assign a_s = ({1'b0, a_q} < NM_L) ? a_q : 2'd0;
    assign d_s = ({1'b0, d_q} < NM_L) ? d_q : 2'd0;
    // Spread the packed master buses into four fixed slots so the 2-bit owner indices select directly.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i] = 1'b0;
            lock[i] = 1'b0;
            wr[i] = 1'b0;
            addr_m[i] = '0;
            wdata_m[i] = '0;
            trans_m[i] = '0;
            size_m[i] = '0;
        end
        for (int i = 0; i < NM; i++) begin
            req[i] = bus.M_HBUSREQ[i];
            lock[i] = bus.M_HLOCK[i];
            wr[i] = bus.M_HWRITE[i];
            addr_m[i] = bus.M_HADDR[32*i +: 32];
            wdata_m[i] = bus.M_HWDATA[32*i +: 32];
            trans_m[i] = bus.M_HTRANS[2*i +: 2];
            size_m[i] = bus.M_HSIZE[3*i +: 3];
        end
    end
`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    others;
    always_comb begin
        others = req;
        others[g_s] = 1'b0;
    end
    assign expired = (cnt_q == LAST) && |others;
    // Saturates so a long uncontested tenure yields at once when a competitor appears.
    assign cnt_d = (g_d != g_q) ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else if (bus.HREADY) cnt_q <= cnt_d;
    end
`else
    assign expired = 1'b0;
`endif
    // Lock always keeps the bus; otherwise the holder keeps it while requesting, else round-robin.
    always_comb begin
        g_d = 2'd0;
        found = 1'b0;
        idx = 2'd0;
        if (lock[g_s] || (req[g_s] && !expired)) begin
            g_d = g_s;
        end else begin
            for (int k = 1; k <= NM; k++) begin
                idx = 2'((int'(g_s) + k) % NM);
                if (!found && req[idx]) begin
                    g_d = idx;
                    found = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            g_q <= 2'd0;
            a_q <= 2'd0;
            d_q <= 2'd0;
            l_q <= 1'b0;
        end else if (bus.HREADY) begin
            d_q <= a_s;
            a_q <= g_s;
            l_q <= lock[g_s];
            g_q <= g_d;
        end
    end
    logic [3:0] gnt;
    assign gnt           = 4'b0001 << g_s;
    assign bus.M_HGRANT  = gnt[NM-1:0];
    assign bus.HADDR     = addr_m[a_s];
    assign bus.HTRANS    = trans_m[a_s];
    assign bus.HWRITE    = wr[a_s];
    assign bus.HSIZE     = size_m[a_s];
    assign bus.HWDATA    = wdata_m[d_s];
    assign bus.HMASTER   = a_s;
    assign bus.HMASTLOCK = l_q;
endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// tb_ahb_lite_bus_arbiter: scoreboard bench for ahb_lite_bus_arbiter (NM=2, MAX_HOLD=4)
module tb_ahb_lite_bus_arbiter;
    localparam int NM = 2;
    localparam int MAX_HOLD = 4;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    ahb_lite_bus_arbiter_if #(.NM(NM)) bif ();
    ahb_lite_bus_arbiter #(.NM(NM), .MAX_HOLD(MAX_HOLD)) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bif)
    );
    always #5 HCLK = ~HCLK;
    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  mst;
        logic        lck;
        logic [31:0] addr;
        logic [5:0]  ctrl;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int mg = 0, ma = 0, md = 0, ml = 0;
`ifdef ARB_HOLD_LIMIT_EN
    int mcnt = 0;
`endif
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] addr_of(input int i);
        return bif.M_HADDR[32*i +: 32];
    endfunction
    function automatic logic [31:0] wdata_of(input int i);
        return bif.M_HWDATA[32*i +: 32];
    endfunction
    function automatic logic [5:0] ctrl_of(input int i);
        return {bif.M_HTRANS[2*i +: 2], bif.M_HWRITE[i], bif.M_HSIZE[3*i +: 3]};
    endfunction
    task automatic drive(input logic [1:0] req, input logic [1:0] lock, input logic rdy);
        bif.M_HBUSREQ = req;
        bif.M_HLOCK = lock;
        bif.HREADY = rdy;
        for (int i = 0; i < NM; i++) begin
            bif.M_HADDR[32*i +: 32] = $urandom;
            bif.M_HWDATA[32*i +: 32] = $urandom;
            bif.M_HTRANS[2*i +: 2] = req[i] ? 2'b10 : 2'b00;
            bif.M_HWRITE[i] = 1'($urandom_range(0, 1));
            bif.M_HSIZE[3*i +: 3] = 3'($urandom_range(0, 2));
        end
    endtask
    // Reference model: advance on the coming edge, then push what the outputs must show after it.
    task automatic model_push(input logic [1:0] req, input logic [1:0] lock, input logic rdy);
        int ng;
        bit hold_out;
        exp_t e;
        hold_out = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        hold_out = (mcnt == MAX_HOLD - 1) && ((req & ~(2'b01 << mg)) != 2'b00);
`endif
        if (lock[mg] || (req[mg] && !hold_out)) ng = mg;
        else begin
            ng = 0;
            for (int j = NM; j >= 1; j--)
                if (req[(mg + j) % NM]) ng = (mg + j) % NM;
        end
        if (rdy) begin
`ifdef ARB_HOLD_LIMIT_EN
            mcnt = (ng != mg) ? 0 : (mcnt + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : mcnt + 1;
`endif
            md = ma;
            ma = mg;
            ml = int'(lock[mg]);
            mg = ng;
        end
        e.gnt = 2'(1 << mg);
        e.mst = 2'(ma);
        e.lck = ml[0];
        e.addr = addr_of(ma);
        e.ctrl = ctrl_of(ma);
        e.wdata = wdata_of(md);
        sb.push_back(e);
    endtask
    task automatic step(input logic [1:0] req, input logic [1:0] lock, input logic rdy);
        exp_t e;
        @(negedge HCLK);
        drive(req, lock, rdy);
        model_push(req, lock, rdy);
        @(posedge HCLK);
        #1;
        e = sb.pop_front();
        check("grant", bif.M_HGRANT, e.gnt);
        check("hmaster", bif.HMASTER, e.mst);
        check("hmastlock", bif.HMASTLOCK, e.lck);
        check("haddr", bif.HADDR, e.addr);
        check("ctrl", {bif.HTRANS, bif.HWRITE, bif.HSIZE}, e.ctrl);
        check("hwdata", bif.HWDATA, e.wdata);
    endtask
    initial begin
        int changes, first_change;
        logic [1:0] prev;
        drive(2'b00, 2'b00, 1'b1);
        #12;
        check("rst_grant", bif.M_HGRANT, 2'b01);
        check("rst_hmaster", bif.HMASTER, 2'd0);
        check("rst_hmastlock", bif.HMASTLOCK, 1'b0);
        check("rst_haddr", bif.HADDR, addr_of(0));
        @(negedge HCLK);
        HRESETn = 1'b1;
        step(2'b10, 2'b00, 1'b1);
        check("lat_grant", bif.M_HGRANT, 2'b10);
        step(2'b10, 2'b00, 1'b1);
        check("lat_hmaster", bif.HMASTER, 2'd1);
        step(2'b10, 2'b00, 1'b1);
        check("lat_hwdata", bif.HWDATA, wdata_of(1));
        repeat (3) step(2'b00, 2'b00, 1'b1);
        check("park", bif.M_HGRANT, 2'b01);
        step(2'b11, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(i % 2 == 0 ? 2'b10 : 2'b01, 2'b00, 1'b1);
            check("alt_grant", bif.M_HGRANT, i % 2 == 0 ? 2'b10 : 2'b01);
        end
        repeat (3) step(2'b00, 2'b00, 1'b1);
        check("park2", bif.M_HGRANT, 2'b01);
        repeat (5) begin
            step(2'b10, 2'b00, 1'b0);
            check("stall_grant", bif.M_HGRANT, 2'b01);
        end
        step(2'b10, 2'b00, 1'b1);
        check("stall_release_grant", bif.M_HGRANT, 2'b10);
        repeat (5) begin
            step(2'b10, 2'b00, 1'b0);
            check("stall_hmaster", bif.HMASTER, 2'd0);
        end
        step(2'b10, 2'b00, 1'b1);
        check("stall_release_hmaster", bif.HMASTER, 2'd1);
        repeat (3) step(2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b01, 1'b1);
            check("lock_grant", bif.M_HGRANT, 2'b01);
            check("lock_hmastlock", bif.HMASTLOCK, 1'b1);
        end
        step(2'b10, 2'b00, 1'b1);
        check("unlock_grant", bif.M_HGRANT, 2'b10);
        changes = 0;
        first_change = 0;
        prev = bif.M_HGRANT;
        for (int i = 1; i <= 12; i++) begin
            step(2'b11, 2'b00, 1'b1);
            if (bif.M_HGRANT != prev) begin
                changes++;
                if (first_change == 0) first_change = i;
            end
            prev = bif.M_HGRANT;
        end
`ifdef ARB_HOLD_LIMIT_EN
        check("hold_rotations", changes, 3);
        check("hold_first_change", first_change, MAX_HOLD);
`else
        check("hold_rotations", changes, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ahb_lite_bus_arbiter.md
Name: ahb_lite_bus_arbiter

Overview:
- Arbitrates the Sys0 AHB-Lite bus between up to four masters (e.g. NfiVe32 CPU, a DMA engine, a debug master) in front of the AHBlite_sys_0 slave fabric.
- Replaces the CPU's tied-off request/grant handshake.
- Owns the grant handshake, the address-phase mux, the data-phase HWDATA mux and HMASTER/HMASTLOCK generation.
- HRDATA and HREADY from the fabric are broadcast to all masters outside this block.

Parameters:
- NM, 2, number of masters (legal 2..4); master 0 is the default (park) master.
- MAX_HOLD, 16, maximum consecutive granted cycles before forced re-arbitration (used only with ARB_HOLD_LIMIT_EN).

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- M_HBUSREQ  in  NM  per-master bus request
- M_HLOCK  in  NM  per-master locked-transfer request
- M_HADDR  in  NM*32  master address buses, master i at [32i+31:32i]
- M_HTRANS  in  NM*2  master HTRANS
- M_HWRITE  in  NM  master HWRITE
- M_HSIZE  in  NM*3  master HSIZE
- M_HWDATA  in  NM*32  master write data
- M_HGRANT  out  NM  one-hot grant
- HREADY  in  1  shared bus ready from fabric
- HADDR  out  32  muxed address to fabric
- HTRANS  out  2  muxed HTRANS
- HWRITE  out  1  muxed HWRITE
- HSIZE  out  3  muxed HSIZE
- HWDATA  out  32  data-phase-muxed write data
- HMASTER  out  2  address-phase owner index
- HMASTLOCK  out  1  locked address phase

Behaviour:
- Reset (async, HRESETn=0): M_HGRANT = one-hot bit 0; internal grant index G=0; address owner A=0; data owner D=0; lock flag L=0; hold counter=0. HMASTER=0 and HMASTLOCK=0; mux outputs follow master 0.
- Address mux: HADDR/HTRANS/HWRITE/HSIZE = master A's signals, combinational.
  - HMASTER = A.
  - HMASTLOCK = L.
- Data mux: HWDATA = M_HWDATA of master D, combinational.
- All state updates occur only on a rising HCLK with HREADY=1. With HREADY=0, G, A, D, L and the counter hold their values.
- Per qualifying edge (HREADY=1), in order using pre-edge values:
  - D <= A.
  - A <= G.
  - L <= M_HLOCK[G].
  - G <= next.
- next computation:
  - If M_HLOCK[G]=1, next = G (lock beats everything, including the hold limit).
  - Else if M_HBUSREQ[G]=1 (and the hold limit has not expired), next = G.
  - Else, round-robin: first i with M_HBUSREQ[i]=1, scanning G+1, G+2, ... modulo NM.
  - If there are no requests, next = 0 (park).
- Latency:
  - Request asserted in cycle n with the bus free and HREADY=1 → M_HGRANT set after edge n.
  - First address phase (HMASTER change) after the next HREADY=1 edge.
  - Data phase one HREADY=1 edge later.
- Ownership of an in-flight data phase is never changed by a new grant; A and D move only together with HREADY.
- A master holding the grant with HTRANS=IDLE keeps it as long as HBUSREQ stays high.
- The arbiter does not force IDLE. An ungranted master's HTRANS is never forwarded, because A is always the granted master.
- Index widths: G, A and D are 2 bits. Values ≥ NM are unreachable; if ever present, they are treated as 0.

Optional Feature:
- Macro ARB_HOLD_LIMIT_EN.
- Defined:
  - A hold counter increments on each HREADY=1 edge where G is unchanged.
  - The counter clears to 0 when G changes.
  - When counter = MAX_HOLD-1, M_HLOCK[G]=0 and another master requests, that master is treated as if M_HBUSREQ[G]=0: grant rotates round-robin.
  - Locked sequences are never cut.
- Undefined: no counter; a requesting master keeps the grant indefinitely.

Test Plan:
- Reset, NM=2, no requests → M_HGRANT=2'b01, HMASTER=0, HMASTLOCK=0, HADDR equals master 0's HADDR.
- Master 1 raises HBUSREQ, HREADY=1 throughout → M_HGRANT=2'b10 after 1 edge, HMASTER=1 after 2 edges; with master 1 HWRITE, HWDATA switches to master 1 after 3 edges.
- Both masters request continuously, each dropping HBUSREQ after 1 transfer → grant alternates 0,1,0,1; with no requests the grant parks at master 0.
- Grant change pending, HREADY held low 5 cycles → M_HGRANT, HMASTER and HWDATA source are frozen; all advance on the first HREADY=1 edge.
- Master 0 asserts HLOCK with a 4-beat burst while master 1 requests → grant stays on 0 until HLOCK drops; HMASTLOCK=1 during those address phases; master 1 is granted on the edge after HLOCK=0.
- ARB_HOLD_LIMIT_EN, MAX_HOLD=4, both masters request continuously and unlocked → grant rotates every 4 HREADY=1 cycles. Without the macro, master 0 keeps the grant.
